pwm_multi: RTL

Multi-channel PWM generator and the parametrised successor to the single-channel 8-bit PWM. NCH channels share one timebase: a prescaler plus an up or up/down counter with a programmable period. Each channel has its own double-buffered duty register, so software updates take effect only at a period boundary and never cause a glitch. The block sits behind the control-register block and drives motor, LED and DAC outputs directly.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_prescaler.sv | 28 ++
 rtl/pwm_multi.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and width helper for the multi-channel PWM
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

  // Counter width for a given range; never narrower than one bit.
  function automatic int ctrlen(input int ctrval);
    return (ctrval > 1) ? $clog2(ctrval) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - timebase prescaler producing one tick every prescale+1 enabled cycles
module pwm_prescaler #(
  parameter int PSLEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PSLEN-1:0] prescale,
  output logic             tick
);

  logic [PSLEN-1:0] psc;

  // Compare against the live prescale value so a change lands on the next compare.
  assign tick = enable && (psc == prescale);

  // Prescale count: clear on tick, advance while enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else if (enable) begin
      psc <= psc + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared timebase and double-buffered duty/period
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int                NCH        = 4,
  parameter  int                CTRVAL     = 256,
  parameter  int                PSLEN      = 8,
  localparam int                CTRLEN     = ctrlen(CTRVAL),
  parameter  logic [CTRLEN-1:0] PERIOD_RST = CTRLEN'(CTRVAL - 1),
  parameter  logic [NCH-1:0]    INVERT     = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PSLEN-1:0]      prescale,
  input  logic [CTRLEN-1:0]     period_in,
  input  logic                  period_we,
  input  logic [NCH*CTRLEN-1:0] duty_in,
  input  logic [NCH-1:0]        duty_we,
  output logic [CTRLEN-1:0]     counter,
  output logic                  period_tick,
  output logic [NCH-1:0]        pwm_out
);

  logic              tick;
  logic              bnd;
  logic [CTRLEN-1:0] ctr_nxt;
  pwm_dir_e          dir;
  pwm_dir_e          dir_nxt;
  logic [CTRLEN-1:0] period_s;
  logic [CTRLEN-1:0] period_a;
  pwm_mode_e         mode_s;
  pwm_mode_e         mode_a;
  logic [NCH-1:0]    raw;

  pwm_prescaler #(.PSLEN(PSLEN)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next count: edge mode wraps at period; center mode turns around at period and at 0.
  always_comb begin
    ctr_nxt = counter;
    dir_nxt = dir;
    if (mode_a == PWM_EDGE) begin
      ctr_nxt = (counter == period_a) ? '0 : counter + 1'b1;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (counter == period_a) begin
        ctr_nxt = (period_a == '0) ? '0 : counter - 1'b1;
        dir_nxt = DIR_DOWN;
      end else begin
        ctr_nxt = counter + 1'b1;
      end
    end else begin
      ctr_nxt = counter - 1'b1;
    end
  end

  // A boundary is any tick that brings the counter back to zero.
  assign bnd = tick && (ctr_nxt == '0);

  // Timebase counter and direction; every boundary restarts the count going up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      dir     <= DIR_UP;
    end else if (tick) begin
      counter <= ctr_nxt;
      dir     <= bnd ? DIR_UP : dir_nxt;
    end
  end

  // Period and mode shadows; a write in the boundary cycle goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_s <= PERIOD_RST;
      period_a <= PERIOD_RST;
      mode_s   <= PWM_EDGE;
      mode_a   <= PWM_EDGE;
    end else begin
      if (period_we) begin
        period_s <= period_in;
        mode_s   <= pwm_mode_e'(mode);
      end
      if (bnd) begin
        period_a <= period_we ? period_in : period_s;
        mode_a   <= period_we ? pwm_mode_e'(mode) : mode_s;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CTRLEN-1:0] duty_wr;
    logic [CTRLEN-1:0] duty_s;
    logic [CTRLEN-1:0] duty_a;

    assign duty_wr = duty_in[i*CTRLEN +: CTRLEN];

    // Per-channel duty shadow, promoted to active only at a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_s <= '0;
        duty_a <= '0;
      end else begin
        if (duty_we[i]) begin
          duty_s <= duty_wr;
        end
        if (bnd) begin
          duty_a <= duty_we[i] ? duty_wr : duty_s;
        end
      end
    end

    assign raw[i] = counter < duty_a;
  end

  // Registered outputs: boundary flag and polarity-adjusted compare results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_tick <= 1'b0;
      pwm_out     <= INVERT;
    end else begin
      period_tick <= bnd;
      pwm_out     <= raw ^ INVERT;
    end
  end

endmodule
